// File: rtl/fft_fp2int_converter.sv
// fft_fp2int_converter: 3-stage fp32 -> int32 converter for 8 lanes (4 complex samples) with valid/ready.
// Defining FP2INT_SAT_FLAG_EN adds the per-lane sat_flag and the sat_count output ports.
module fft_fp2int_converter #(
    parameter int FRAC_BITS = 0
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_areset,
    input  logic [63:0] data_0,
    input  logic [63:0] data_1,
    input  logic [63:0] data_2,
    input  logic [63:0] data_3,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] result_0,
    output logic [63:0] result_1,
    output logic [63:0] result_2,
    output logic [63:0] result_3,
    output logic        out_valid,
    input  logic        out_ready
`ifdef FP2INT_SAT_FLAG_EN
    ,
    output logic [7:0]  sat_flag,
    output logic [15:0] sat_count
`endif
);
    typedef enum logic [1:0] {C_NORM, C_ZERO, C_INF, C_NAN} cls_t;
    logic         adv;
    logic [2:0]   vld_q, vld_d;
    logic [255:0] din, res_w;
`ifdef FP2INT_SAT_FLAG_EN
    logic [7:0]   flag_w;
`endif
    assign din       = {data_3, data_2, data_1, data_0};
    assign adv       = !vld_q[2] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[2];
    assign vld_d     = adv ? {vld_q[1:0], in_valid} : vld_q;
    assign result_0  = res_w[63:0];
    assign result_1  = res_w[127:64];
    assign result_2  = res_w[191:128];
    assign result_3  = res_w[255:192];
    always_ff @(posedge s_axi_aclk) begin
        vld_q <= s_axi_areset ? 3'b000 : vld_d;
    end
    for (genvar l = 0; l < 8; l++) begin : g_lane
        logic [31:0]        lane_in;
        logic               s1_q, s2_q, ovf2_q, ovf_d, big, sat_d;
        logic signed [9:0]  e1_q, e_d;
        logic [22:0]        f1_q;
        cls_t               c1_q, c2_q, c_d;
        logic [32:0]        base, mag_d, mag2_q, rnd;
        logic [5:0]         sl, sr;
        logic [31:0]        res_q, res_d;
        assign lane_in = din[32*l +: 32];
        always_comb begin
            e_d   = {2'b00, lane_in[30:23]} - 10'd127 + 10'(FRAC_BITS);
            c_d   = (lane_in[30:23] == 8'hFF) ? ((lane_in[22:0] != '0) ? C_NAN : C_INF) :
                    (lane_in[30:23] == 8'h00) ? C_ZERO : C_NORM;
            // magnitude carries one guard bit: mag = 1.frac * 2^(e+1)
            base  = {9'd0, 1'b1, f1_q};
            sl    = 6'(e1_q - 10'sd22);
            sr    = 6'(10'sd22 - e1_q);
            mag_d = (e1_q < -10'sd1) ? '0 : (e1_q >= 10'sd22) ? base << sl : base >> sr;
            // exactly -2^31 still fits, so it is not treated as overflow
            ovf_d = (e1_q > 10'sd31) | ((e1_q == 10'sd31) & !(s1_q & (f1_q == '0)));
            rnd   = {1'b0, mag2_q[32:1]} + 33'(mag2_q[0]);
            big   = s2_q ? (rnd > 33'h080000000) : (rnd > 33'h07FFFFFFF);
            sat_d = (c2_q == C_NAN) | (c2_q == C_INF) | ((c2_q == C_NORM) & (ovf2_q | big));
            res_d = ((c2_q == C_NAN) | (c2_q == C_ZERO)) ? '0 :
                    sat_d ? (s2_q ? 32'h80000000 : 32'h7FFFFFFF) :
                    s2_q ? -rnd[31:0] : rnd[31:0];
        end
        always_ff @(posedge s_axi_aclk) begin
            if (s_axi_areset) begin
                s1_q   <= 1'b0;
                e1_q   <= '0;
                f1_q   <= '0;
                c1_q   <= C_ZERO;
                s2_q   <= 1'b0;
                c2_q   <= C_ZERO;
                ovf2_q <= 1'b0;
                mag2_q <= '0;
                res_q  <= '0;
            end else if (adv) begin
                s1_q   <= lane_in[31];
                e1_q   <= e_d;
                f1_q   <= lane_in[22:0];
                c1_q   <= c_d;
                s2_q   <= s1_q;
                c2_q   <= c1_q;
                ovf2_q <= ovf_d;
                mag2_q <= mag_d;
                res_q  <= res_d;
            end
        end
        assign res_w[32*l +: 32] = res_q;
`ifdef FP2INT_SAT_FLAG_EN
        logic sat_q;
        always_ff @(posedge s_axi_aclk) begin
            if (s_axi_areset)
                sat_q <= 1'b0;
            else if (adv)
                sat_q <= sat_d;
        end
        assign flag_w[l] = sat_q;
`endif
    end
`ifdef FP2INT_SAT_FLAG_EN
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_sum;
    always_comb begin
        cnt_sum = {1'b0, cnt_q} + 17'($countones(flag_w));
        cnt_d   = (out_valid & out_ready) ? (cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0]) : cnt_q;
    end
    always_ff @(posedge s_axi_aclk) begin
        cnt_q <= s_axi_areset ? '0 : cnt_d;
    end
    assign sat_flag  = flag_w;
    assign sat_count = cnt_q;
`endif
endmodule

// File: tb/tb_fft_fp2int_converter.sv
// tb_fft_fp2int_converter: directed-vector bench for fft_fp2int_converter (FRAC_BITS=0 and FRAC_BITS=8 instances).
module tb_fft_fp2int_converter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic         rst, in_valid, in_ready, out_valid, in_valid8, in_ready8, out_valid8;
    logic         out_ready  = 1'b1;
    logic         out_ready8 = 1'b1;
    logic [255:0] din, din8, res, res8;
    logic [63:0]  r0, r1, r2, r3, p0, p1, p2, p3;
    int           n_vec = 0, n_err = 0, mode = 0;
    logic [255:0] q_res[$];
    logic [7:0]   q_flg[$];
`ifdef FP2INT_SAT_FLAG_EN
    logic [7:0]   flg, flg8;
    logic [15:0]  cnt, cnt8;
    int           exp_cnt = 0;
`endif
    assign res  = {r3, r2, r1, r0};
    assign res8 = {p3, p2, p1, p0};

    fft_fp2int_converter #(.FRAC_BITS(0)) u_dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .data_0(din[63:0]), .data_1(din[127:64]), .data_2(din[191:128]), .data_3(din[255:192]),
        .in_valid(in_valid), .in_ready(in_ready),
        .result_0(r0), .result_1(r1), .result_2(r2), .result_3(r3),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef FP2INT_SAT_FLAG_EN
        , .sat_flag(flg), .sat_count(cnt)
`endif
    );

    fft_fp2int_converter #(.FRAC_BITS(8)) u_dut8 (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .data_0(din8[63:0]), .data_1(din8[127:64]), .data_2(din8[191:128]), .data_3(din8[255:192]),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .result_0(p0), .result_1(p1), .result_2(p2), .result_3(p3),
        .out_valid(out_valid8), .out_ready(out_ready8)
`ifdef FP2INT_SAT_FLAG_EN
        , .sat_flag(flg8), .sat_count(cnt8)
`endif
    );

    // FRAC_BITS=0 vectors: fp32 input, hand-computed int32 result, saturation flag mask
    logic [31:0] tf0 [16] = '{32'h3F800000, 32'hC0200000, 32'h3F000000, 32'h3EFFFFFF,
                              32'hBF000000, 32'h00000001, 32'h80000000, 32'h4F32D05E,
                              32'hCF000000, 32'h7FC00000, 32'hFF800000, 32'h7F800000,
                              32'h42F60000, 32'hC0600000, 32'h4EFFFFFF, 32'hCF000001};
    logic [31:0] tr0 [16] = '{32'h00000001, 32'hFFFFFFFD, 32'h00000001, 32'h00000000,
                              32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h7FFFFFFF,
                              32'h80000000, 32'h00000000, 32'h80000000, 32'h7FFFFFFF,
                              32'h0000007B, 32'hFFFFFFFC, 32'h7FFFFF80, 32'h80000000};
    logic [15:0] fl0 = 16'h8E80;
    // FRAC_BITS=8 vectors; only the last one saturates
    logic [31:0] tf8 [8] = '{32'h3FC00000, 32'h3F800000, 32'hBF000000, 32'h40600000,
                             32'h42F60000, 32'h00000000, 32'h3B800000, 32'h4B000000};
    logic [31:0] tr8 [8] = '{32'h00000180, 32'h00000100, 32'hFFFFFF80, 32'h00000380,
                             32'h00007B00, 32'h00000000, 32'h00000001, 32'h7FFFFFFF};

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void mk0(input int k, output logic [255:0] d, output logic [255:0] r, output logic [7:0] f);
        for (int l = 0; l < 8; l++) begin
            d[32*l +: 32] = tf0[(k + l) % 16];
            r[32*l +: 32] = tr0[(k + l) % 16];
            f[l]          = fl0[(k + l) % 16];
        end
    endfunction

    function automatic void mk8(input int k, output logic [255:0] d, output logic [255:0] r, output logic [7:0] f);
        for (int l = 0; l < 8; l++) begin
            d[32*l +: 32] = tf8[(k + l) % 8];
            r[32*l +: 32] = tr8[(k + l) % 8];
            f[l]          = ((k + l) % 8) == 7;
        end
    endfunction

    task automatic drive(input logic [255:0] d, input logic [255:0] r, input logic [7:0] f);
        logic acc;
        int   n;
        din = d; in_valid = 1'b1; acc = 1'b0; n = 0;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (acc) begin
            q_res.push_back(r);
            q_flg.push_back(f);
        end else
            chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (q_res.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q_res.size() != 0)
            chk("drain_timeout", q_res.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // out_ready: 0 = always ready, 1 = pseudo-random, 2 = stalled
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    initial begin : monitor
        logic         stall = 1'b0;
        logic [255:0] held, e;
        logic [7:0]   ef;
`ifdef FP2INT_SAT_FLAG_EN
        logic [7:0]   heldf;
`endif
        forever begin
            @(negedge clk);
            if (rst)
                stall = 1'b0;
            else begin
                chk("in_ready_rule", in_ready, !(out_valid & !out_ready));
                if (stall) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_result", res, held);
`ifdef FP2INT_SAT_FLAG_EN
                    chk("hold_flag", flg, heldf);
`endif
                end
                if (out_valid & out_ready) begin
                    if (q_res.size() == 0)
                        chk("spurious_beat", out_valid, 0);
                    else begin
                        e  = q_res.pop_front();
                        ef = q_flg.pop_front();
                        chk("result", res, e);
`ifdef FP2INT_SAT_FLAG_EN
                        chk("sat_flag", flg, ef);
                        exp_cnt = (exp_cnt + $countones(ef) > 65535) ? 65535 : exp_cnt + $countones(ef);
`endif
                    end
                end
                stall = out_valid & !out_ready;
                held  = res;
`ifdef FP2INT_SAT_FLAG_EN
                heldf = flg;
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [255:0] d, r;
        logic [7:0]   f;
        rst = 1'b1; din = '0; din8 = '0; in_valid = 1'b0; in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", res, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef FP2INT_SAT_FLAG_EN
        chk("rst_sat_flag", flg, 0);
        chk("rst_sat_count", cnt, 0);
`endif
        rst = 1'b0;
        // single beat: 1.0 / -2.5 lanes, latency 3
        drive({4{32'hC0200000, 32'h3F800000}}, {4{32'hFFFFFFFD, 32'h00000001}}, 8'h00);
        chk("lat_cycle1", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_cycle2", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_cycle3", out_valid, 1);
        chk("lat_result", res, {4{32'hFFFFFFFD, 32'h00000001}});
        drain();
        // every table entry through every lane: rounding, tiny values, specials
        for (int k = 0; k < 16; k++) begin
            mk0(k, d, r, f);
            drive(d, r, f);
        end
        drain();
`ifdef FP2INT_SAT_FLAG_EN
        chk("sat_count_stream", cnt, exp_cnt);
`endif
        // random backpressure
        mode = 1;
        for (int k = 0; k < 48; k++) begin
            mk0(k * 7, d, r, f);
            drive(d, r, f);
        end
        mode = 0;
        drain();
`ifdef FP2INT_SAT_FLAG_EN
        chk("sat_count_bp", cnt, exp_cnt);
`endif
        // FRAC_BITS=8 back-to-back stream, one result per cycle after fill
        for (int c = 0; c < 20; c++) begin
            if (c < 16) begin
                mk8(c, d, r, f);
                din8 = d;
                in_valid8 = 1'b1;
            end else
                in_valid8 = 1'b0;
            @(posedge clk);
            #1;
            chk("t4_in_ready", in_ready8, 1);
            if (c >= 2 && c < 18) begin
                mk8(c - 2, d, r, f);
                chk("t4_valid", out_valid8, 1);
                chk("t4_result", res8, r);
`ifdef FP2INT_SAT_FLAG_EN
                chk("t4_flag", flg8, f);
`endif
            end else
                chk("t4_idle", out_valid8, 0);
        end
        // reset with three beats held in a stalled pipeline
        mode = 2;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            mk0(k + 7, d, r, f);
            drive(d, r, f);
        end
        chk("t6_full", out_valid, 1);
        rst = 1'b1;
        q_res.delete();
        q_flg.delete();
`ifdef FP2INT_SAT_FLAG_EN
        exp_cnt = 0;
`endif
        @(posedge clk);
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_result", res, 0);
`ifdef FP2INT_SAT_FLAG_EN
        chk("t6_sat_count", cnt, 0);
`endif
        rst = 1'b0;
        mode = 0;
        repeat (8) @(posedge clk);
        #1;
        mk0(12, d, r, f);
        drive(d, r, f);
        drain();
`ifdef FP2INT_SAT_FLAG_EN
        chk("t6_sat_count_after", cnt, exp_cnt);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
